// File: rtl/bus_req_initiator.sv
// Initiator side of the four-phase pending/done handshake. It accepts one command at a time,
// holds the bus request, and reports completion or a timeout abort.
module bus_req_initiator #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wr_data,
    output logic                  pending,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rd_data,
    output logic                  resp_err
);
    typedef enum logic [1:0] {IDLE, REQ, RELEASE, RESP} state_t;

    // The timer counts cycles already spent in REQ or RELEASE, so expiry happens on the TIMEOUT-th cycle.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    sync1_q, done_s_q;
    logic [15:0]             timer_q, timer_d;
    logic                    pending_q, pending_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wr_data_q, bus_wr_data_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    err_q, err_d;
    logic                    accept;
    logic                    expired;

    assign accept  = (state_q == IDLE) && cmd_ready_q && cmd_valid;
    assign expired = (timer_q == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b0;
            done_s_q      <= 1'b0;
            timer_q       <= '0;
            pending_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= done;
            done_s_q      <= sync1_q;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            cmd_ready_q   <= cmd_ready_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (done_s_q || expired) state_d = RELEASE;
            RELEASE: if (!done_s_q || expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        err_d         = err_q;
        timer_d       = expired ? timer_q : timer_q + 16'd1;
        if ((state_d != state_q) && ((state_d == REQ) || (state_d == RELEASE))) begin
            timer_d = '0;
        end
        if (accept) begin
            bus_we_d      = cmd_we;
            bus_addr_d    = cmd_addr;
            bus_wr_data_d = cmd_wr_data;
        end
        if ((state_q == REQ) && (state_d == RELEASE)) begin
            err_d = !done_s_q;
            if (done_s_q && !bus_we_q) begin
                rd_data_d = bus_rd_data;
            end
        end
        // A responder still holding done when RELEASE expires is also an abort.
        if ((state_q == RELEASE) && (state_d == RESP) && done_s_q) begin
            err_d = 1'b1;
        end
        pending_d   = (state_q == REQ) && (state_d == REQ);
        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready    = cmd_ready_q;
    assign pending      = pending_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wr_data  = bus_wr_data_q;
    assign resp_valid   = (state_q == RESP);
    assign resp_rd_data = rd_data_q;
    assign resp_err     = err_q;
endmodule

// File: tb/tb_bus_req_initiator.sv
// Directed bench for bus_req_initiator. It covers read, write, timeout, back-to-back commands,
// reset mid-transfer, and a jittery asynchronous responder.
`timescale 1ns/1ps
module tb_bus_req_initiator;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rclk = 1'b0;
    logic          reset;
    logic          cmdValid;
    logic          cmdReady;
    logic          cmdWe;
    logic [AW-1:0] cmdAddr;
    logic [DW-1:0] cmdWrData;
    logic          pending;
    logic          busWe;
    logic [AW-1:0] busAddr;
    logic [DW-1:0] busWrData;
    logic          done;
    logic [DW-1:0] busRdData;
    logic          respValid;
    logic [DW-1:0] respRdData;
    logic          respErr;

    // Responder source: 0 = directed, 1 = async 16 MHz responder, 2 = instant echo of pending.
    logic [1:0]    mode;
    logic          directDone;
    logic [DW-1:0] directRdData;
    logic          asyncDone = 1'b0;
    logic [DW-1:0] asyncData = '0;
    int            asyncAcks = 0;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] b2bAddr [3];
    logic          b2bWe [3];
    logic [DW-1:0] b2bData [3];
    logic [DW-1:0] expRd;
    logic          wasAccepting;
    logic          rWe;
    logic [AW-1:0] rAddr;
    logic [DW-1:0] rData;
    int            acc, rsp, lastAcc, readyViol, waited, acksBefore;
    int            respCount, asyncErrs, ackErrs, dupErrs;

    always #5 clk = ~clk;
    always #31.25 rclk = ~rclk;

    assign done      = (mode == 2'd2) ? pending : ((mode == 2'd1) ? asyncDone : directDone);
    assign busRdData = (mode == 2'd2) ? (busAddr[7:0] ^ 8'hC3) :
                       ((mode == 2'd1) ? asyncData : directRdData);

    bus_req_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmdValid),
        .cmd_ready   (cmdReady),
        .cmd_we      (cmdWe),
        .cmd_addr    (cmdAddr),
        .cmd_wr_data (cmdWrData),
        .pending     (pending),
        .bus_we      (busWe),
        .bus_addr    (busAddr),
        .bus_wr_data (busWrData),
        .done        (done),
        .bus_rd_data (busRdData),
        .resp_valid  (respValid),
        .resp_rd_data(respRdData),
        .resp_err    (respErr)
    );

    // Responder on an unrelated clock, with random sub-period jitter on each done edge.
    always @(posedge rclk) begin
        if (mode == 2'd1) begin
            if (pending && !asyncDone) begin
                #($urandom_range(1, 15));
                asyncData <= 8'($urandom);
                asyncAcks <= asyncAcks + 1;
                asyncDone <= 1'b1;
            end else if (!pending && asyncDone) begin
                #($urandom_range(1, 15));
                asyncDone <= 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data);
        cmdValid  = valid;
        cmdWe     = we;
        cmdAddr   = addr;
        cmdWrData = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One directed transfer: done is raised ackDelay cycles after pending rises. A conflicting
    // command is held on the input meanwhile, and it must be ignored.
    task automatic doTransfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] rdata, input int ackDelay, input logic [DW-1:0] expRdIn);
        checkOutput("xfer_ready_before", 32'(cmdReady), 32'd1);
        applyStimulus(1'b1, we, addr, wdata);
        tick(1);
        applyStimulus(1'b1, ~we, ~addr, ~wdata);
        checkOutput("xfer_ready_drop", 32'(cmdReady), 32'd0);
        checkOutput("xfer_pending_latency", 32'(pending), 32'd0);
        tick(1);
        checkOutput("xfer_pending_rise", 32'(pending), 32'd1);
        for (int i = 0; i < ackDelay; i++) begin
            tick(1);
            checkOutput("xfer_pending_wait", 32'(pending), 32'd1);
            checkOutput("xfer_addr_hold", 32'(busAddr), 32'(addr));
            checkOutput("xfer_wdata_hold", 32'(busWrData), 32'(wdata));
            checkOutput("xfer_we_hold", 32'(busWe), 32'(we));
        end
        directRdData = rdata;
        directDone   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            checkOutput("xfer_pending_sync", 32'(pending), 32'd1);
        end
        tick(1);
        checkOutput("xfer_pending_fall", 32'(pending), 32'd0);
        checkOutput("xfer_rd_data", 32'(respRdData), 32'(expRdIn));
        checkOutput("xfer_addr_hold2", 32'(busAddr), 32'(addr));
        checkOutput("xfer_wdata_hold2", 32'(busWrData), 32'(wdata));
        directDone = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            checkOutput("xfer_no_early_resp", 32'(respValid), 32'd0);
        end
        tick(1);
        checkOutput("xfer_resp_valid", 32'(respValid), 32'd1);
        checkOutput("xfer_resp_err", 32'(respErr), 32'd0);
        checkOutput("xfer_ready_in_resp", 32'(cmdReady), 32'd0);
        checkOutput("xfer_addr_in_resp", 32'(busAddr), 32'(addr));
        tick(1);
        checkOutput("xfer_resp_one_cycle", 32'(respValid), 32'd0);
        checkOutput("xfer_ready_back", 32'(cmdReady), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        mode         = 2'd0;
        directDone   = 1'b0;
        directRdData = '0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick(3);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_ready", 32'(cmdReady), 32'd0);
        checkOutput("rst_bus_addr", 32'(busAddr), 32'd0);
        checkOutput("rst_bus_we", 32'(busWe), 32'd0);
        checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst_resp_err", 32'(respErr), 32'd0);
        checkOutput("rst_rd_data", 32'(respRdData), 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("rst_ready_after", 32'(cmdReady), 32'd1);

        $display("[TB] read and write transfers");
        doTransfer(1'b0, 17'h1E800, 8'h00, 8'hA5, 2, 8'hA5);
        doTransfer(1'b1, 17'h08000, 8'h3C, 8'h77, 1, 8'hA5);

        $display("[TB] timeout abort");
        applyStimulus(1'b1, 1'b0, 17'h00123, 8'h00);
        tick(1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int i = 1; i < TO; i++) begin
            tick(1);
            checkOutput("to_pending_high", 32'(pending), 32'd1);
        end
        tick(1);
        checkOutput("to_pending_fall", 32'(pending), 32'd0);
        checkOutput("to_no_early_resp", 32'(respValid), 32'd0);
        tick(1);
        checkOutput("to_resp_valid", 32'(respValid), 32'd1);
        checkOutput("to_resp_err", 32'(respErr), 32'd1);
        checkOutput("to_rd_data_kept", 32'(respRdData), 32'hA5);
        tick(1);
        checkOutput("to_resp_one_cycle", 32'(respValid), 32'd0);
        checkOutput("to_ready_back", 32'(cmdReady), 32'd1);
        doTransfer(1'b0, 17'h1FFFF, 8'h00, 8'h5A, 0, 8'h5A);

        $display("[TB] back-to-back commands with instant responder");
        mode    = 2'd2;
        b2bAddr = '{17'h00A11, 17'h15500, 17'h0FF3C};
        b2bWe   = '{1'b0, 1'b1, 1'b0};
        b2bData = '{8'h01, 8'hE7, 8'h02};
        expRd   = 8'h5A;
        acc = 0; rsp = 0; lastAcc = 0; readyViol = 0;
        applyStimulus(1'b1, b2bWe[0], b2bAddr[0], b2bData[0]);
        for (int c = 0; c < 60 && rsp < 3; c++) begin
            wasAccepting = cmdReady && cmdValid;
            tick(1);
            if (wasAccepting) begin
                if (acc > 0) checkOutput("b2b_spacing", 32'(c - lastAcc), 32'd9);
                lastAcc = c;
                acc++;
                if (acc < 3) applyStimulus(1'b1, b2bWe[acc], b2bAddr[acc], b2bData[acc]);
                else applyStimulus(1'b0, 1'b0, '0, '0);
            end
            if ((acc > rsp) && !respValid && cmdReady) readyViol++;
            if (respValid) begin
                if (!b2bWe[rsp]) expRd = b2bAddr[rsp][7:0] ^ 8'hC3;
                checkOutput("b2b_rd_data", 32'(respRdData), 32'(expRd));
                checkOutput("b2b_err", 32'(respErr), 32'd0);
                checkOutput("b2b_order_addr", 32'(busAddr), 32'(b2bAddr[rsp]));
                rsp++;
            end
        end
        checkOutput("b2b_accepts", 32'(acc), 32'd3);
        checkOutput("b2b_resps", 32'(rsp), 32'd3);
        checkOutput("b2b_ready_low", 32'(readyViol), 32'd0);
        tick(1);
        mode = 2'd0;

        $display("[TB] reset during REQ");
        applyStimulus(1'b1, 1'b0, 17'h02468, 8'h00);
        tick(1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick(2);
        checkOutput("rstreq_pending_before", 32'(pending), 32'd1);
        reset = 1'b1;
        tick(1);
        checkOutput("rstreq_pending", 32'(pending), 32'd0);
        checkOutput("rstreq_ready", 32'(cmdReady), 32'd0);
        checkOutput("rstreq_bus_addr", 32'(busAddr), 32'd0);
        checkOutput("rstreq_resp_valid", 32'(respValid), 32'd0);
        tick(1);
        reset = 1'b0;
        checkOutput("rstreq_resp_valid2", 32'(respValid), 32'd0);
        tick(1);
        checkOutput("rstreq_ready_after", 32'(cmdReady), 32'd1);
        checkOutput("rstreq_resp_valid3", 32'(respValid), 32'd0);

        $display("[TB] reset during RELEASE");
        applyStimulus(1'b1, 1'b0, 17'h13579, 8'h00);
        tick(1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick(1);
        directRdData = 8'h99;
        directDone   = 1'b1;
        tick(3);
        checkOutput("rstrel_pending_low", 32'(pending), 32'd0);
        checkOutput("rstrel_captured", 32'(respRdData), 32'h99);
        tick(1);
        checkOutput("rstrel_no_resp", 32'(respValid), 32'd0);
        reset      = 1'b1;
        directDone = 1'b0;
        tick(1);
        checkOutput("rstrel_pending", 32'(pending), 32'd0);
        checkOutput("rstrel_ready", 32'(cmdReady), 32'd0);
        checkOutput("rstrel_rd_data", 32'(respRdData), 32'd0);
        checkOutput("rstrel_resp_valid", 32'(respValid), 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("rstrel_ready_after", 32'(cmdReady), 32'd1);
        checkOutput("rstrel_resp_valid2", 32'(respValid), 32'd0);

        $display("[TB] 1000 commands against async responder");
        mode = 2'd1;
        expRd = '0;
        respCount = 0; asyncErrs = 0; ackErrs = 0; dupErrs = 0;
        for (int n = 0; n < 1000; n++) begin
            rWe   = 1'($urandom);
            rAddr = AW'($urandom);
            rData = DW'($urandom);
            waited = 0;
            while (!cmdReady && waited < 100) begin
                tick(1);
                waited++;
            end
            if (!cmdReady) begin
                checkOutput("async_ready_timeout", 32'(cmdReady), 32'd1);
                break;
            end
            acksBefore = asyncAcks;
            applyStimulus(1'b1, rWe, rAddr, rData);
            tick(1);
            applyStimulus(1'b0, 1'b0, '0, '0);
            waited = 0;
            while (!respValid && waited < 100) begin
                tick(1);
                waited++;
            end
            if (!respValid) begin
                checkOutput("async_resp_timeout", 32'(respValid), 32'd1);
                break;
            end
            if (!rWe) expRd = asyncData;
            checkOutput("async_rd_data", 32'(respRdData), 32'(expRd));
            if (respErr) asyncErrs++;
            if (asyncAcks - acksBefore != 1) ackErrs++;
            respCount++;
            tick(1);
            if (respValid) dupErrs++;
        end
        checkOutput("async_resps", 32'(respCount), 32'd1000);
        checkOutput("async_err_flags", 32'(asyncErrs), 32'd0);
        checkOutput("async_ack_count", 32'(ackErrs), 32'd0);
        checkOutput("async_dup_resp", 32'(dupErrs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_req_initiator.md
# bus_req_initiator

Initiator side of the four-phase `pending`/`done` bus-access handshake. Accepts read/write commands from the MCU/SPI command path on a valid/ready interface and drives `pending` with stable address, write data and direction. It waits for the responder's `done`, captures read data, then withdraws `pending` and waits for `done` to fall before reporting completion. It sits between the SPI command decoder and the bus-cycle responder and includes `done` synchronisation and a timeout abort.

## Interface
- `ADDR_WIDTH`, 17: bus address width.
- `DATA_WIDTH`, 8: bus data width.
- `TIMEOUT`, 1023: cycles to wait for `done` rise (or fall) before abort; legal range 4..65535.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: block can accept a command.
- `cmd_we` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_WIDTH: command address.
- `cmd_wr_data` input DATA_WIDTH: write data.
- `pending` output 1: request to responder; registered.
- `bus_we` output 1: held direction.
- `bus_addr` output ADDR_WIDTH: held address.
- `bus_wr_data` output DATA_WIDTH: held write data.
- `done` input 1: responder acknowledge; may be asynchronous to `clk`.
- `bus_rd_data` input DATA_WIDTH: responder read data; valid while `done` is high.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rd_data` output DATA_WIDTH: captured read data; held until next capture.
- `resp_err` output 1: qualifies `resp_valid`; 1 = timeout abort.

## Operation
- `done` passes through a 2-flop synchroniser → `done_s`. The FSM uses only `done_s`.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`: latch `cmd_we/addr/wr_data` into `bus_*`, clear the timer, go to REQ.
  - REQ: `pending`=1. On `done_s`=1: capture `bus_rd_data` into `resp_rd_data` (reads only; writes leave it unchanged), set err=0, go to RELEASE. On timer = TIMEOUT: set err=1, go to RELEASE.
  - RELEASE: `pending`=0. On `done_s`=0: go to RESP. On timer = TIMEOUT: set err=1, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, `resp_err`=err, then go to IDLE.
- The timer resets on entry to REQ and on entry to RELEASE, and saturates at TIMEOUT.
- `bus_we`, `bus_addr` and `bus_wr_data` are stable from the `pending` rise through RESP. They change only on acceptance in IDLE.
- `cmd_valid` outside IDLE is ignored; there is no queuing.
- `done_s`=1 already high on entry to REQ (stale responder): it is treated as an acknowledge. The responder guarantees `done` is low while `pending` is low, so this case occurs only after a timeout abort.

## Timing
- Reset values: `pending`=0, `cmd_ready`=0, `bus_we`=0, `bus_addr`=0, `bus_wr_data`=0, `resp_valid`=0, `resp_err`=0, `resp_rd_data`=0, state IDLE, synchroniser flops 0.
- `cmd_ready` is registered. It is 1 from the first cycle after `reset` deasserts while in IDLE, and drops the cycle after acceptance.
- Acceptance at edge N → `pending`=1 after edge N+1.
- `done` rising before edge M → `done_s`=1 after M+1. The capture and `pending`=0 follow at M+2.
- `done` falling before edge K → `done_s`=0 after K+1, RESP after K+2, `resp_valid` high for that cycle, `cmd_ready`=1 the next cycle.
- Minimum command-to-command spacing with an instant responder is 9 cycles.
- Timeout abort asserts after exactly TIMEOUT cycles in REQ with `done_s`=0. `pending` is low on the next cycle.
- `reset` mid-operation: all outputs return to their reset values on the next edge. `pending` drops immediately, with no `resp_valid` for the in-flight command.

## Test plan
- Read: accept addr 0x1E800, responder returns 0xA5 three cycles after `pending` → `resp_valid`=1, `resp_err`=0, `resp_rd_data`=0xA5; `pending` high through `done_s` rise; `bus_addr` stable throughout.
- Write: we=1, addr 0x08000, data 0x3C; responder acknowledges → one `resp_valid` with `resp_err`=0; `resp_rd_data` unchanged from its prior value; `bus_wr_data`=0x3C for the whole `pending` window.
- Timeout: TIMEOUT=16, responder silent → `pending` falls exactly 16 cycles after entering REQ; `resp_valid`=1 with `resp_err`=1; next command accepted normally.
- Back-to-back: `cmd_valid` held high for 3 commands → exactly 3 `resp_valid` pulses in order; `cmd_ready` low between acceptance and RESP; no command dropped or duplicated.
- Async `done` with jitter (responder on an unrelated 16 MHz clock) → no missed or double acknowledges over 1000 random read/write commands; read data matches the scoreboard.
- Reset in REQ and in RELEASE → `pending`=0 and `cmd_ready`=0 the next cycle, no `resp_valid`; `cmd_ready`=1 the first cycle after `reset` deasserts.
